// File: rtl/alu_core.sv
// Registered 5-bit arithmetic unit: add, subtract, multiply and restoring divide.
// The result and the producing mode are captured together on each rising slow_clock.
module alu_core #(
    parameter int WIDTH = 5
) (
    input  logic               slow_clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         mode,
    output logic [2*WIDTH-1:0] out,
    output logic [1:0]         state
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_MUL = 2'd2,
        MODE_DIV = 2'd3
    } mode_e;

    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [RW-1:0]    out_d;
    logic [RW-1:0]    out_q;
    logic [1:0]       state_d;
    logic [1:0]       state_q;

    assign a_ext = {{WIDTH{1'b0}}, A};
    assign b_ext = {{WIDTH{1'b0}}, B};

    // Unrolled restoring divider; rem stays below 2*B so WIDTH+1 bits suffice.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rem = '0;
        quo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], A[i]};
            if (rem >= {1'b0, B}) begin
                rem    = rem - {1'b0, B};
                quo[i] = 1'b1;
            end
        end
    end

    always_comb begin
        out_d   = '0;
        state_d = mode;
        case (mode_e'(mode))
            MODE_ADD: out_d = a_ext + b_ext;
            MODE_SUB: out_d = a_ext - b_ext;
            MODE_MUL: out_d = a_ext * b_ext;
            MODE_DIV: begin
                if (B == '0) begin
                    out_d = '1;
                end else begin
                    out_d = {rem[WIDTH-1:0], quo};
                end
            end
            default:  out_d = '0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            out_q   <= '0;
            state_q <= '0;
        end else begin
            out_q   <= out_d;
            state_q <= state_d;
        end
    end

    assign out   = out_q;
    assign state = state_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core: hand-computed vectors with
// immediate assertions at every comparison point.
module tb_alu_core;

    logic       slow_clock;
    logic       reset;
    logic [4:0] A;
    logic [4:0] B;
    logic [1:0] mode;
    logic [9:0] out;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    alu_core dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .mode       (mode),
        .out        (out),
        .state      (state)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input logic [9:0] exp_out, input logic [1:0] exp_state);
        checks++;
        assert (out === exp_out) else begin
            failures++;
            $error("FAIL %s out: observed=0x%03h expected=0x%03h", tag, out, exp_out);
        end
        checks++;
        assert (state === exp_state) else begin
            failures++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, state, exp_state);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b, input logic [1:0] m,
                        input string tag, input logic [9:0] exp_out, input logic [1:0] exp_state);
        @(negedge slow_clock);
        reset = r;
        A     = a;
        B     = b;
        mode  = m;
        @(posedge slow_clock);
        #1;
        check(tag, exp_out, exp_state);
    endtask

    initial begin
        reset = 1'b0;
        A     = 5'd10;
        B     = 5'd10;
        mode  = 2'd2;

        // Reset held for two edges, then released.
        step(1'b0, 5'd10, 5'd10, 2'd2, "rst_edge1", 10'd0, 2'd0);
        step(1'b0, 5'd10, 5'd10, 2'd2, "rst_edge2", 10'd0, 2'd0);
        step(1'b1, 5'd10, 5'd10, 2'd2, "rst_release", 10'd100, 2'd2);

        // A=10, B=10 across all modes.
        step(1'b1, 5'd10, 5'd10, 2'd0, "10_10_add", 10'd20, 2'd0);
        step(1'b1, 5'd10, 5'd10, 2'd1, "10_10_sub", 10'd0, 2'd1);
        step(1'b1, 5'd10, 5'd10, 2'd2, "10_10_mul", 10'd100, 2'd2);
        step(1'b1, 5'd10, 5'd10, 2'd3, "10_10_div", 10'd1, 2'd3);

        // A=15, B=5 across all modes.
        step(1'b1, 5'd15, 5'd5, 2'd0, "15_5_add", 10'd20, 2'd0);
        step(1'b1, 5'd15, 5'd5, 2'd1, "15_5_sub", 10'd10, 2'd1);
        step(1'b1, 5'd15, 5'd5, 2'd2, "15_5_mul", 10'd75, 2'd2);
        step(1'b1, 5'd15, 5'd5, 2'd3, "15_5_div", 10'd3, 2'd3);

        // Boundaries.
        step(1'b1, 5'd31, 5'd31, 2'd2, "max_mul", 10'd961, 2'd2);
        step(1'b1, 5'd31, 5'd31, 2'd0, "max_add", 10'd62, 2'd0);
        step(1'b1, 5'd5, 5'd15, 2'd1, "neg_sub", 10'h3F6, 2'd1);
        step(1'b1, 5'd0, 5'd31, 2'd1, "zero_sub", 10'h3E1, 2'd1);
        step(1'b1, 5'd0, 5'd31, 2'd0, "zero_add", 10'd31, 2'd0);
        step(1'b1, 5'd0, 5'd31, 2'd2, "zero_mul", 10'd0, 2'd2);
        step(1'b1, 5'd0, 5'd7, 2'd3, "zero_div", 10'd0, 2'd3);

        // Divide with remainder and divide by zero.
        step(1'b1, 5'd29, 5'd4, 2'd3, "div_29_4", 10'd39, 2'd3);
        step(1'b1, 5'd31, 5'd3, 2'd3, "div_31_3", {5'd1, 5'd10}, 2'd3);
        step(1'b1, 5'd7, 5'd0, 2'd3, "div_by_zero", 10'h3FF, 2'd3);

        // Inputs changing between edges must not disturb the registered output.
        #1;
        A    = 5'd3;
        B    = 5'd2;
        mode = 2'd0;
        #2;
        check("hold_between_edges", 10'h3FF, 2'd3);

        // Reset in the middle of a stream of operations.
        step(1'b1, 5'd12, 5'd9, 2'd0, "mid_op1", 10'd21, 2'd0);
        step(1'b1, 5'd12, 5'd9, 2'd1, "mid_op2", 10'd3, 2'd1);
        step(1'b1, 5'd12, 5'd9, 2'd2, "mid_op3", 10'd108, 2'd2);
        step(1'b0, 5'd12, 5'd9, 2'd3, "mid_reset", 10'd0, 2'd0);
        step(1'b1, 5'd12, 5'd9, 2'd3, "mid_resume_div", {5'd3, 5'd1}, 2'd3);
        step(1'b1, 5'd9, 5'd12, 2'd1, "mid_resume_sub", 10'h3FD, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
